// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: holds the fetch PC and picks redirect, predicted target or next 8-byte block.
// Define FETCH_TAKEN_BUBBLE_EN to insert one bubble after every accepted predicted-taken fetch.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hFFFF_FFF0,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             reset,
  output logic [31:0]      pred_pc,
  input  logic [31:0]      pred_target_curr,
  input  logic             pred_taken_curr,
  input  logic             pred_hit_curr,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic             fetch_pred_taken,
  output logic [31:0]      fetch_pred_target,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] perf_taken_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, BUBBLE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        handshake;
  logic        count_taken;

  assign fetch_valid       = (state == RUN);
  assign fetch_pred_taken  = fetch_valid & pred_hit_curr & pred_taken_curr;
  assign fetch_pred_target = fetch_valid ? pred_target_curr : 32'h0;
  assign handshake         = fetch_valid & fetch_ready;
  assign count_taken       = handshake & fetch_pred_taken;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pred_pc;
    unique case (state)
      IDLE:   state_nxt = RUN;
      BUBBLE: state_nxt = RUN;
      RUN: begin
        if (handshake) begin
          if (fetch_pred_taken) begin
            pc_nxt = pred_target_curr;
`ifdef FETCH_TAKEN_BUBBLE_EN
            state_nxt = BUBBLE;
`endif
          end else begin
            // Low 3 bits cleared: the next block is aligned even when pc is not.
            pc_nxt = {pred_pc[31:3] + 29'd1, 3'b000};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Redirect overrides everything, including an accepted request this cycle.
    if (redirect_valid) begin
      pc_nxt    = redirect_pc;
      state_nxt = BUBBLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      pred_pc <= RESET_PC;
    end else begin
      state   <= state_nxt;
      pred_pc <= pc_nxt;
    end
  end

  // Counts the request even when a redirect lands in the same cycle; saturates instead of wrapping.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      perf_taken_cnt <= '0;
    end else if (count_taken && (perf_taken_cnt != {CNT_W{1'b1}})) begin
      perf_taken_cnt <= perf_taken_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen; small counter width so saturation is reached by real handshakes.
module tb_fetch_pc_gen;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             reset;
  logic [31:0]      pred_pc;
  logic [31:0]      pred_target_curr;
  logic             pred_taken_curr;
  logic             pred_hit_curr;
  logic             fetch_valid;
  logic             fetch_ready;
  logic             fetch_pred_taken;
  logic [31:0]      fetch_pred_target;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] perf_taken_cnt;

  int vectors    = 0;
  int miscompares = 0;

  fetch_pc_gen #(.RESET_PC(32'h0000_1000), .CNT_W(CNT_W)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .pred_pc          (pred_pc),
    .pred_target_curr (pred_target_curr),
    .pred_taken_curr  (pred_taken_curr),
    .pred_hit_curr    (pred_hit_curr),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .fetch_pred_taken (fetch_pred_taken),
    .fetch_pred_target(fetch_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .perf_taken_cnt   (perf_taken_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pred(input logic hit, input logic taken, input logic [31:0] target);
    pred_hit_curr    = hit;
    pred_taken_curr  = taken;
    pred_target_curr = target;
  endtask

  // Redirect, then leave the bubble so pred_pc is a valid request again.
  task automatic go_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
    step();
  endtask

  // One accepted predicted-taken fetch; leaves any bubble first.
  task automatic taken_hs(input logic [31:0] target);
    set_pred(1'b1, 1'b1, target);
    if (!fetch_valid) step();
    step();
  endtask

  initial begin
    reset          = 1'b1;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    set_pred(1'b0, 1'b0, 32'h0);
    #2 reset = 1'b0;
    #1;
    check("rst_pc", pred_pc, 32'h0000_1000);
    check("rst_valid", {31'h0, fetch_valid}, 32'h0);
    check("rst_ptaken", {31'h0, fetch_pred_taken}, 32'h0);
    check("rst_ptarget", fetch_pred_target, 32'h0);
    check("rst_cnt", {28'h0, perf_taken_cnt}, 32'h0);
    step();
    step();
    reset = 1'b1;

    // Reset release: IDLE for one cycle, then sequential blocks with no bubbles.
    check("idle_valid", {31'h0, fetch_valid}, 32'h0);
    step();
    check("run_valid", {31'h0, fetch_valid}, 32'h1);
    check("seq0", pred_pc, 32'h0000_1000);
    step();
    check("seq1", pred_pc, 32'h0000_1008);
    step();
    check("seq2", pred_pc, 32'h0000_1010);

    // Taken prediction with BTB hit.
    go_to(32'h0000_2000);
    check("at_2000", pred_pc, 32'h0000_2000);
    set_pred(1'b1, 1'b1, 32'h0000_3004);
    #1;
    check("ptaken_comb", {31'h0, fetch_pred_taken}, 32'h1);
    check("ptarget_comb", fetch_pred_target, 32'h0000_3004);
    step();
    set_pred(1'b0, 1'b0, 32'h0);
    check("taken_pc", pred_pc, 32'h0000_3004);
    check("taken_cnt", {28'h0, perf_taken_cnt}, 32'h1);
`ifdef FETCH_TAKEN_BUBBLE_EN
    check("taken_bubble", {31'h0, fetch_valid}, 32'h0);
    step();
    check("taken_bubble_end", {31'h0, fetch_valid}, 32'h1);
`else
    check("taken_nobubble", {31'h0, fetch_valid}, 32'h1);
`endif

    // Taken direction on a BTB miss falls through sequentially.
    go_to(32'h0000_2000);
    set_pred(1'b0, 1'b1, 32'h0000_3004);
    #1;
    check("miss_ptaken", {31'h0, fetch_pred_taken}, 32'h0);
    step();
    check("miss_pc", pred_pc, 32'h0000_2008);
    check("miss_cnt", {28'h0, perf_taken_cnt}, 32'h1);

    // Stall with a taken prediction pending: nothing moves.
    fetch_ready = 1'b0;
    set_pred(1'b1, 1'b1, 32'h0000_3004);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pred_pc, 32'h0000_2008);
      check("stall_valid", {31'h0, fetch_valid}, 32'h1);
      check("stall_cnt", {28'h0, perf_taken_cnt}, 32'h1);
    end
    fetch_ready = 1'b1;

    // Redirect coincident with a taken handshake: redirect wins, request still counted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    step();
    redirect_valid = 1'b0;
    set_pred(1'b0, 1'b0, 32'h0);
    check("redir_pc", pred_pc, 32'h0000_5000);
    check("redir_valid", {31'h0, fetch_valid}, 32'h0);
    check("redir_ptarget", fetch_pred_target, 32'h0);
    check("redir_cnt", {28'h0, perf_taken_cnt}, 32'h2);
    step();
    check("redir_valid2", {31'h0, fetch_valid}, 32'h1);
    check("redir_pc2", pred_pc, 32'h0000_5000);

    // Back-to-back redirects, the second during BUBBLE: last one wins, bubble extends.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_6000;
    step();
    redirect_pc    = 32'h0000_7000;
    step();
    redirect_valid = 1'b0;
    check("b2b_pc", pred_pc, 32'h0000_7000);
    check("b2b_valid", {31'h0, fetch_valid}, 32'h0);
    step();
    check("b2b_valid2", {31'h0, fetch_valid}, 32'h1);

    // Unaligned PC at the top of memory wraps to an aligned zero block.
    go_to(32'hFFFF_FFFC);
    check("top_pc", pred_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", pred_pc, 32'h0000_0000);

    // Saturation: 13 more taken handshakes take the counter from 2 to 15.
    for (int i = 0; i < 13; i++) taken_hs(32'h0000_0100);
    check("sat_full", {28'h0, perf_taken_cnt}, 32'hF);
    taken_hs(32'h0000_0100);
    check("sat_hold", {28'h0, perf_taken_cnt}, 32'hF);
    set_pred(1'b0, 1'b0, 32'h0);

    // Reset in BUBBLE takes effect between clock edges.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_8000;
    step();
    redirect_valid = 1'b0;
    check("pre_rst_pc", pred_pc, 32'h0000_8000);
    #2 reset = 1'b0;
    #1;
    check("async_pc", pred_pc, 32'h0000_1000);
    check("async_valid", {31'h0, fetch_valid}, 32'h0);
    check("async_cnt", {28'h0, perf_taken_cnt}, 32'h0);
    check("async_ptarget", fetch_pred_target, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
